axi_dma_r_sched: RTL and testbench
==================================

// Module: axi_dma_r_sched
// PURPOSE
//  Shares the AXI read DMA engine between N_REQ requesters (weight, feature-map, bias loaders).
//  Each accepted request is a base address plus a burst count. The block issues one DMA burst
//  at a time, advances the address, forwards beats tagged with the requester id, and pulses
//  done when the request completes. It sits between the loaders and the read DMA engine.
// PARAMETERS
//  N_REQ        2      number of requesters (2..8)
//  ADDR_W       32     DDR byte address width (`DDR_ADDR_W)
//  DATA_W       256    beat width (`MIG_BUS_W)
//  BURST_BEATS  17     beats per DMA burst (arlen 16 + 1)
//  NBURST_W     16     width of per-request burst count
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous, active-high reset
//  req_valid    in   N_REQ           request pending, one bit per requester
//  req_ready    out  N_REQ           one-hot request accept (handshake)
//  req_addr     in   N_REQ*ADDR_W    base byte address, packed, requester 0 in LSBs
//  req_nbursts  in   N_REQ*NBURST_W  bursts to read, packed
//  dma_valid    out  1               burst start to DMA engine
//  dma_addr     out  ADDR_W          burst address to DMA engine
//  dma_ready    in   1               per-beat strobe from DMA engine
//  dma_rdata    in   DATA_W          beat data from DMA engine
//  out_valid    out  1               beat valid (no backpressure; consumer must accept)
//  out_data     out  DATA_W          beat data
//  out_id       out  $clog2(N_REQ)   owner of current beat
//  out_last     out  1               final beat of final burst of the request
//  done         out  N_REQ           one-cycle pulse, one-hot, request finished
// BEHAVIOUR
//  Reset: state IDLE; req_ready, dma_valid, out_valid, out_last, done = 0; dma_addr, counters,
//   grant id = 0; round-robin pointer = 0 (requester 0 highest). Reset mid-transfer discards it.
//  IDLE: arbitrate over req_valid; winner g gets req_ready[g]=1 in the same cycle (comb.);
//   latch addr, nbursts, id. nbursts==0 -> DONE, else -> ISSUE. No requests -> stay.
//  ISSUE: dma_valid=1 for exactly one cycle, dma_addr=latched addr -> DATA.
//  DATA: out_valid=dma_ready, out_data=dma_rdata, out_id=grant id (zero latency, comb.).
//   Each dma_ready increments beat_cnt. On beat BEATS-1: beat_cnt=0, bursts_left-1,
//   addr += BURST_BEATS*DATA_W/8 (mod 2^ADDR_W wrap); bursts_left was 1 -> out_last=1, DONE;
//   else -> ISSUE (next cycle, DMA is back in IDLE).
//  DONE: done[id]=1 one cycle; RR pointer = id+1 mod N_REQ -> IDLE.
//  dma_ready outside DATA is ignored (no beat forwarded). req inputs only sampled in IDLE.
//  Request-to-first dma_valid latency: 1 cycle. Inter-burst gap: 1 cycle (ISSUE).
//  req_valid may drop without accept; no error. Simultaneous requests resolved by arbiter.
// CONFIGURATION
//  AXI_DMA_R_SCHED_PRIO_EN defined: fixed priority, lowest index wins, RR pointer unused.
//  Not defined: round-robin starting at RR pointer, updated in DONE.
// STRUCTURE
//  Shared package/header axi_dma.vh: state encodings (IDLE, ISSUE, DATA, DONE), BURST_BYTES
//   constant. Sub-module axi_dma_r_arb: combinational N_REQ arbiter (req, pointer -> one-hot
//   grant + index), holds the PRIO_EN switch.
// TESTING
//  1 req0 addr=0x1000 nbursts=2 -> dma_addr 0x1000 then 0x1220 (DATA_W=256), 34 beats id=0,
//    out_last on beat 34 only, done[0] one cycle after.
//  2 req0,req1 valid same cycle, RR: req0 served, then req1; repeat -> req1 first after req0.
//    With AXI_DMA_R_SCHED_PRIO_EN: req0 always first.
//  3 nbursts=0 -> req_ready pulse, no dma_valid, done pulse 1 cycle later.
//  4 addr=0xFFFFFF00, nbursts=2 -> second dma_addr wraps to 0x00000120.
//  5 rst asserted during DATA beat 5 -> next cycle all outputs 0, state IDLE, new request
//    served normally.
//  6 dma_ready gaps (1 beat every 3 cycles) -> beat count exact, dma_valid once per burst.

Source files
------------

// File: rtl/axi_dma_r_sched_pkg.sv
// Shared types for the AXI read DMA scheduler: FSM state encoding and burst sizing helper.
package axi_dma_r_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bytes covered by one DMA burst; the address advances by this much per burst.
    function automatic int burst_bytes(input int beats, input int data_w);
        return beats * data_w / 8;
    endfunction

endpackage

// File: rtl/axi_dma_r_sched_arb.sv
// Combinational requester arbiter: round-robin from ptr, or fixed lowest-index priority
// when AXI_DMA_R_SCHED_PRIO_EN is defined (ptr is then ignored).
module axi_dma_r_sched_arb #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int ID_W = $clog2(N_REQ);

`ifdef AXI_DMA_R_SCHED_PRIO_EN
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Scan high to low so the lowest requesting index is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
                any    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Scan from furthest to nearest offset so the requester closest to ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
                any    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/axi_dma_r_sched.sv
// Shares the AXI read DMA engine between N_REQ loaders, one burst at a time, tagging beats
// with the owner id. Define AXI_DMA_R_SCHED_PRIO_EN for fixed priority instead of round-robin.
module axi_dma_r_sched
    import axi_dma_r_sched_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 256,
    parameter int BURST_BEATS = 17,
    parameter int NBURST_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*NBURST_W-1:0] req_nbursts,
    output logic                      dma_valid,
    output logic [ADDR_W-1:0]         dma_addr,
    input  logic                      dma_ready,
    input  logic [DATA_W-1:0]         dma_rdata,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0]  out_id,
    output logic                      out_last,
    output logic [N_REQ-1:0]          done
);

    localparam int ID_W        = $clog2(N_REQ);
    localparam int BEAT_W      = $clog2(BURST_BEATS);
    localparam int BURST_BYTES = burst_bytes(BURST_BEATS, DATA_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NBURST_W-1:0] nb_q, nb_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ID_W-1:0]     rr_q, rr_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;

    axi_dma_r_sched_arb #(.N_REQ(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign dma_addr = addr_q;
    assign out_data = dma_rdata;
    assign out_id   = id_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nb_d      = nb_q;
        id_d      = id_q;
        beat_d    = beat_q;
        rr_d      = rr_q;
        req_ready = '0;
        dma_valid = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = '0;
        case (state_q)
            ST_IDLE: begin
                // Hold off the handshake while reset is applied so nothing is accepted and lost.
                if (arb_any && !rst) begin
                    req_ready = arb_gnt;
                    addr_d    = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    nb_d      = req_nbursts[arb_idx*NBURST_W +: NBURST_W];
                    id_d      = arb_idx;
                    beat_d    = '0;
                    state_d   = (nb_d == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dma_valid = 1'b1;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (dma_ready) begin
                    out_valid = 1'b1;
                    if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                        beat_d = '0;
                        nb_d   = nb_q - NBURST_W'(1);
                        addr_d = addr_q + ADDR_W'(BURST_BYTES);
                        if (nb_q == NBURST_W'(1)) begin
                            out_last = 1'b1;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_ISSUE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done[id_q] = 1'b1;
                rr_d       = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            nb_q    <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nb_q    <= nb_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_axi_dma_r_sched.sv
// Directed bench for axi_dma_r_sched: DMA responder model, passive monitor, hand-computed
// expectations for addresses, beat counts, grant order, done timing and mid-transfer reset.
module tb_axi_dma_r_sched;

    localparam int N_REQ       = 2;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 256;
    localparam int BURST_BEATS = 17;
    localparam int NBURST_W    = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*NBURST_W-1:0] req_nbursts;
    logic                      dma_valid;
    logic [ADDR_W-1:0]         dma_addr;
    logic                      dma_ready;
    logic [DATA_W-1:0]         dma_rdata;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [0:0]                out_id;
    logic                      out_last;
    logic [N_REQ-1:0]          done;

    always #5 clk = ~clk;

    axi_dma_r_sched #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BURST_BEATS(BURST_BEATS), .NBURST_W(NBURST_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_nbursts(req_nbursts),
        .dma_valid(dma_valid), .dma_addr(dma_addr),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_last(out_last), .done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // DMA engine model: after each dma_valid, deliver BURST_BEATS beats, one every gap+1 cycles.
    int   gap   = 0;
    logic stray = 1'b0;
    int   dma_left  = 0;
    int   dma_phase = 0;
    initial begin
        dma_ready = 1'b0;
        dma_rdata = '0;
        forever begin
            @(posedge clk); #2;
            dma_ready = 1'b0;
            if (rst) begin
                dma_left  = 0;
                dma_phase = 0;
            end else if (dma_valid) begin
                dma_left  = BURST_BEATS;
                dma_phase = 0;
            end else if (dma_left > 0) begin
                if (dma_phase == 0) begin
                    dma_ready = 1'b1;
                    dma_rdata = {8{$urandom}};
                    dma_left--;
                end
                dma_phase = (dma_phase == gap) ? 0 : dma_phase + 1;
            end else if (stray) begin
                dma_ready = 1'b1;
                dma_rdata = {8{$urandom}};
            end
        end
    end

    // Passive monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              clr = 1'b0;
    int                exp_id = -1;
    logic [N_REQ-1:0]  last_ready = '0;
    int m_beats, m_last_cnt, m_last_at, m_last_cyc, m_done_cyc, m_grant_cyc, m_issue_cyc;
    int m_data_err, m_id_err;
    logic [ADDR_W-1:0] m_addr[$];
    int                m_grant[$];
    logic [N_REQ-1:0]  m_done[$];

    always @(negedge clk) begin
        int g;
        g = 0;
        last_ready = req_ready;
        if (clr) begin
            m_beats = 0; m_last_cnt = 0; m_last_at = 0; m_last_cyc = 0; m_done_cyc = 0;
            m_grant_cyc = 0; m_issue_cyc = 0; m_data_err = 0; m_id_err = 0;
            m_addr.delete(); m_grant.delete(); m_done.delete();
        end else begin
            if (req_ready != '0) begin
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
                m_grant.push_back(g);
                if (m_grant.size() == 1) m_grant_cyc = cyc;
            end
            if (dma_valid) begin
                m_addr.push_back(dma_addr);
                if (m_addr.size() == 1) m_issue_cyc = cyc;
            end
            if (out_valid) begin
                m_beats++;
                if (out_data !== dma_rdata) m_data_err++;
                if (exp_id >= 0 && int'(out_id) != exp_id) m_id_err++;
            end
            if (out_last) begin
                m_last_cnt++;
                m_last_at  = m_beats;
                m_last_cyc = cyc;
            end
            if (done != '0) begin
                m_done.push_back(done);
                m_done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        req_valid = req_valid & ~last_ready;
    endtask

    task automatic settle();
        #5;
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        tick(); settle();
        clr = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [NBURST_W-1:0] n);
        req_addr[i*ADDR_W +: ADDR_W]       = a;
        req_nbursts[i*NBURST_W +: NBURST_W] = n;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (m_done.size() < n && k < budget) begin
            tick(); settle();
            k++;
        end
        check(tag, m_done.size(), n);
        tick(); settle();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 0);
        check({tag, " dma_valid"}, dma_valid, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_last"},  out_last, 0);
        check({tag, " done"},      done, 0);
        check({tag, " dma_addr"},  dma_addr, 0);
        check({tag, " out_id"},    out_id, 0);
    endtask

    int first_id;
    int k;

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_nbursts = '0;
        repeat (3) tick();
        settle();
        check_idle_outputs("reset");
        tick(); rst = 1'b0; settle();

        // dma_ready while idle must not produce a beat
        clear_mon();
        tick(); stray = 1'b1; settle();
        tick(); stray = 1'b0; settle();
        tick(); settle();
        check("stray beats", m_beats, 0);

        // T1: two bursts from req0
        clear_mon();
        tick(); set_req(0, 32'h0000_1000, 16'd2); exp_id = 0; settle();
        wait_done(1, 200, "t1 done count");
        check("t1 issues", m_addr.size(), 2);
        check("t1 addr0", m_addr[0], 32'h0000_1000);
        check("t1 addr1", m_addr[1], 32'h0000_1220);
        check("t1 beats", m_beats, 34);
        check("t1 id err", m_id_err, 0);
        check("t1 data err", m_data_err, 0);
        check("t1 last cnt", m_last_cnt, 1);
        check("t1 last at", m_last_at, 34);
        check("t1 done val", m_done[0], 2'b01);
        check("t1 done lat", m_done_cyc - m_last_cyc, 1);
        check("t1 issue lat", m_issue_cyc - m_grant_cyc, 1);

        // T2b: both requesters after req0 was served last
`ifdef AXI_DMA_R_SCHED_PRIO_EN
        first_id = 0;
`else
        first_id = 1;
`endif
        clear_mon();
        tick(); set_req(0, 32'h0000_2000, 16'd1); set_req(1, 32'h0000_3000, 16'd1);
        exp_id = -1; settle();
        wait_done(2, 200, "t2b done count");
        check("t2b grants", m_grant.size(), 2);
        check("t2b grant0", m_grant[0], first_id);
        check("t2b grant1", m_grant[1], 1 - first_id);
        check("t2b done0", m_done[0], (first_id == 0) ? 2'b01 : 2'b10);
        check("t2b addr0", m_addr[0], (first_id == 0) ? 32'h0000_2000 : 32'h0000_3000);
        check("t2b beats", m_beats, 34);

        // T2a: fresh pointer, both requesters -> req0 first in either mode
        tick(); rst = 1'b1; tick(); rst = 1'b0; settle();
        clear_mon();
        tick(); set_req(0, 32'h0000_2000, 16'd1); set_req(1, 32'h0000_3000, 16'd1); settle();
        wait_done(2, 200, "t2a done count");
        check("t2a grant0", m_grant[0], 0);
        check("t2a grant1", m_grant[1], 1);
        check("t2a done1", m_done[1], 2'b10);

        // T3: zero bursts
        clear_mon();
        tick(); set_req(0, 32'h0000_7000, 16'd0); settle();
        wait_done(1, 20, "t3 done count");
        check("t3 issues", m_addr.size(), 0);
        check("t3 beats", m_beats, 0);
        check("t3 done val", m_done[0], 2'b01);
        check("t3 done lat", m_done_cyc - m_grant_cyc, 1);

        // T4: address wrap, requester 1
        clear_mon();
        tick(); set_req(1, 32'hFFFF_FF00, 16'd2); exp_id = 1; settle();
        wait_done(1, 200, "t4 done count");
        check("t4 addr0", m_addr[0], 32'hFFFF_FF00);
        check("t4 addr1", m_addr[1], 32'h0000_0120);
        check("t4 beats", m_beats, 34);
        check("t4 id err", m_id_err, 0);
        check("t4 done val", m_done[0], 2'b10);

        // T6: sparse dma_ready, one beat every three cycles
        gap = 2;
        clear_mon();
        tick(); set_req(0, 32'h0000_4000, 16'd2); exp_id = 0; settle();
        wait_done(1, 400, "t6 done count");
        check("t6 issues", m_addr.size(), 2);
        check("t6 addr1", m_addr[1], 32'h0000_4220);
        check("t6 beats", m_beats, 34);
        check("t6 last at", m_last_at, 34);
        check("t6 data err", m_data_err, 0);
        gap = 0;

        // T5: reset in the middle of a transfer, then a normal request
        clear_mon();
        tick(); set_req(0, 32'h0000_5000, 16'd3); settle();
        k = 0;
        while (m_beats < 5 && k < 100) begin
            tick(); settle();
            k++;
        end
        check("t5 beats pre", m_beats, 5);
        tick(); rst = 1'b1; settle();
        tick(); rst = 1'b0; settle();
        check_idle_outputs("t5 post rst");
        repeat (4) begin tick(); settle(); end
        check("t5 no more beats", m_beats, 5);
        clear_mon();
        tick(); set_req(1, 32'h0000_6000, 16'd1); exp_id = 1; settle();
        wait_done(1, 100, "t5 done count");
        check("t5 addr", m_addr[0], 32'h0000_6000);
        check("t5 beats", m_beats, 17);
        check("t5 last at", m_last_at, 17);
        check("t5 done val", m_done[0], 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
